// File: rtl/inv_permute_pkg.sv
// Shared types and constants for the inverse lane permutation engine.
// Holds the FSM state encoding and the 5x5 lane geometry.
package inv_permute_pkg;

    localparam int LANES = 25;
    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_LANE = 5'd24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/inv_permute_if.sv
// Memory-side bus of inv_permute: start/ready handshake, source read port,
// destination write port and done pulse. abort exists only with INV_PERMUTE_ABORT_EN.
interface inv_permute_if
    import inv_permute_pkg::*;
#(
    parameter int W = 64
);
    logic             start;
`ifdef INV_PERMUTE_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             rd;
    logic [IDX_W-1:0] rd_addr;
    logic [W-1:0]     rd_data;
    logic             wr;
    logic [IDX_W-1:0] wr_addr;
    logic [W-1:0]     wr_data;
    logic             done;

    // Requester side: issues start and serves the source memory.
    modport master (
        output start,
`ifdef INV_PERMUTE_ABORT_EN
        output abort,
`endif
        output rd_data,
        input  ready, rd, rd_addr, wr, wr_addr, wr_data, done
    );

    // Engine side.
    modport slave (
        input  start,
`ifdef INV_PERMUTE_ABORT_EN
        input  abort,
`endif
        input  rd_data,
        output ready, rd, rd_addr, wr, wr_addr, wr_data, done
    );

endinterface

// File: rtl/inv_permute_map.sv
// Combinational lane remap: source (X,Y) goes to destination ((X+3Y) mod 5, X),
// with lane index i = x + 5y.
module inv_permute_map
    import inv_permute_pkg::*;
(
    input  logic [IDX_W-1:0] src,
    output logic [IDX_W-1:0] dst
);

    logic [IDX_W-1:0] sx;
    logic [IDX_W-1:0] sy;
    logic [IDX_W-1:0] dx;

    // All intermediates fit in 5 bits: 4 + 3*4 = 16 and 4 + 5*4 = 24.
    always_comb begin
        sx  = src % 5'd5;
        sy  = src / 5'd5;
        dx  = (sx + 5'd3 * sy) % 5'd5;
        dst = (src > LAST_LANE) ? '0 : dx + 5'd5 * sx;
    end

endmodule

// File: rtl/inv_permute.sv
// Inverse 5x5 lane permutation engine: streams 25 source lanes, writes each to its
// remapped destination one cycle later. Optional INV_PERMUTE_ABORT_EN adds an abort input.
module inv_permute
    import inv_permute_pkg::*;
#(
    parameter int W     = 64,
    parameter int LANES = 25
) (
    input  logic          clk,
    input  logic          rst,
    inv_permute_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             wr_vld_q, wr_vld_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] dst_idx;

    // NOTE: every always_comb output gets a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_vld_d = 1'b0;
        wr_idx_d = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    cnt_d   = '0;
                end
            end
            READ: begin
                wr_vld_d = 1'b1;
                wr_idx_d = cnt_q;
                if (cnt_q == LAST) state_d = DRAIN;
                else               cnt_d   = cnt_q + 1'b1;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef INV_PERMUTE_ABORT_EN
        // Abort drops the read issued this cycle, so its write never appears.
        if (bus.abort && (state_q == READ || state_q == DRAIN)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            wr_vld_d = 1'b0;
            wr_idx_d = '0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_vld_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_vld_q <= wr_vld_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    inv_permute_map u_map (
        .src (wr_idx_q),
        .dst (dst_idx)
    );

    // Read data arrives one cycle after rd, in step with the registered index.
    assign bus.ready   = (state_q == IDLE);
    assign bus.rd      = (state_q == READ);
    assign bus.rd_addr = (state_q == READ) ? cnt_q : '0;
    assign bus.done    = (state_q == DONE);
    assign bus.wr      = wr_vld_q;
    assign bus.wr_addr = wr_vld_q ? dst_idx : '0;
    assign bus.wr_data = wr_vld_q ? bus.rd_data : {W{1'b0}};

endmodule

// File: tb/tb_inv_permute.sv
// Directed testbench for inv_permute: reset, mapping, round trip, ignored start,
// mid-run reset, back-to-back start and (with INV_PERMUTE_ABORT_EN) abort.
module tb_inv_permute;

    logic clk;
    logic rst;

    inv_permute_if #(.W(64)) bus ();

    inv_permute #(.W(64), .LANES(25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [63:0] src_mem  [25];
    logic [63:0] dst_mem  [25];
    logic [63:0] orig_mem [25];
    bit          rd_log    [64];
    bit          wr_log    [64];
    bit          ready_log [64];
    bit          done_log  [64];
    logic [24:0] seen;
    int          cyc;
    int          wr_count;
    int          done_count;
    int          done_cyc;
    int          viol;
    int          tests_run;
    int          tests_failed;
`ifdef INV_PERMUTE_ABORT_EN
    int          abort_cyc;
`endif

    // Source memory: one-cycle read latency, garbage when not read.
    always @(posedge clk or negedge rst) begin
        if (!rst)        bus.rd_data <= '0;
        else if (bus.rd) bus.rd_data <= src_mem[bus.rd_addr];
        else             bus.rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Runs n+1 cycles (cycle 0 drives start) and logs the outputs of each cycle.
    task automatic run_job(input int n, input bit hold_start, input int s1, input int s2,
                           input int rst_c, input int rst_rel);
        wr_count   = 0;
        done_count = 0;
        done_cyc   = -1;
        viol       = 0;
        seen       = '0;
        for (int i = 0; i < 25; i++) dst_mem[i] = '1;
        for (int i = 0; i < 64; i++) begin
            rd_log[i] = 0; wr_log[i] = 0; ready_log[i] = 0; done_log[i] = 0;
        end
        cyc = -1;
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.start = hold_start || (cyc == 0) || (cyc == s1) || (cyc == s2);
`ifdef INV_PERMUTE_ABORT_EN
            bus.abort = (cyc == abort_cyc);
`endif
            if (cyc == rst_c)   rst = 1'b0;
            if (cyc == rst_rel) rst = 1'b1;
            @(negedge clk);
            if (cyc < 64) begin
                rd_log[cyc]    = bus.rd;
                wr_log[cyc]    = bus.wr;
                ready_log[cyc] = bus.ready;
                done_log[cyc]  = bus.done;
            end
            if (bus.wr) begin
                wr_count++;
                if (bus.wr_addr < 5'd25) begin
                    dst_mem[bus.wr_addr] = bus.wr_data;
                    seen[bus.wr_addr]    = 1'b1;
                end else begin
                    viol++;
                end
            end
            if (bus.done) begin
                done_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (!bus.wr && (bus.wr_addr != 0 || bus.wr_data != 0)) viol++;
            if (!bus.rd && bus.rd_addr != 0) viol++;
        end
        bus.start = 1'b0;
`ifdef INV_PERMUTE_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({bus.ready, bus.rd, bus.wr, bus.done} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL reset_outputs: ready/rd/wr/done got %b expected 1000",
                         {bus.ready, bus.rd, bus.wr, bus.done});
            end
            tests_run++;
            if (bus.rd_addr !== 5'd0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 64'd0) begin
                tests_failed++;
                $display("FAIL reset_buses: rd_addr=%0d wr_addr=%0d wr_data=%h expected all 0",
                         bus.rd_addr, bus.wr_addr, bus.wr_data);
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.ready !== 1'b1 || bus.rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b rd=%b expected ready=1 rd=0", bus.ready, bus.rd);
        end
    endtask

    task automatic test_single_run();
        for (int i = 0; i < 25; i++) src_mem[i] = 64'(i);
        run_job(28, 1'b0, -1, -1, -1, -1);
        tests_run++;
        if (rd_log[0] !== 1'b0 || rd_log[1] !== 1'b1 || rd_log[25] !== 1'b1 || rd_log[26] !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_window: rd at cycles 0/1/25/26 got %b%b%b%b expected 0110",
                     rd_log[0], rd_log[1], rd_log[25], rd_log[26]);
        end
        tests_run++;
        if (wr_log[1] !== 1'b0 || wr_log[2] !== 1'b1 || wr_log[26] !== 1'b1 || wr_log[27] !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_window: wr at cycles 1/2/26/27 got %b%b%b%b expected 0110",
                     wr_log[1], wr_log[2], wr_log[26], wr_log[27]);
        end
        tests_run++;
        if (done_cyc !== 27 || done_count !== 1) begin
            tests_failed++;
            $display("FAIL done_timing: done at cycle %0d count %0d expected cycle 27 count 1",
                     done_cyc, done_count);
        end
        tests_run++;
        if (ready_log[27] !== 1'b0 || ready_log[28] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_return: ready at 27/28 got %b%b expected 01", ready_log[27], ready_log[28]);
        end
        tests_run++;
        if (wr_count !== 25 || $countones(seen) !== 25) begin
            tests_failed++;
            $display("FAIL write_coverage: writes %0d distinct %0d expected 25/25",
                     wr_count, $countones(seen));
        end
        tests_run++;
        if (dst_mem[0] !== 64'd0 || dst_mem[6] !== 64'd1 || dst_mem[3] !== 64'd5 || dst_mem[21] !== 64'd24) begin
            tests_failed++;
            $display("FAIL map_corners: dst[0,6,3,21] got %0d,%0d,%0d,%0d expected 0,1,5,24",
                     dst_mem[0], dst_mem[6], dst_mem[3], dst_mem[21]);
        end
        tests_run++;
        if (dst_mem[10] !== 64'd7 || dst_mem[19] !== 64'd13) begin
            tests_failed++;
            $display("FAIL map_inner: dst[10,19] got %0d,%0d expected 7,13", dst_mem[10], dst_mem[19]);
        end
        tests_run++;
        if (viol !== 0) begin
            tests_failed++;
            $display("FAIL idle_buses_zero: %0d violations expected 0", viol);
        end
    endtask

    task automatic test_round_trip();
        int x, y, fwd;
        for (int i = 0; i < 25; i++) orig_mem[i] = {$urandom, $urandom};
        // Forward permute: lane (x,y) moves to (y, (2x+3y) mod 5).
        for (int i = 0; i < 25; i++) begin
            x   = i % 5;
            y   = i / 5;
            fwd = y + 5 * ((2 * x + 3 * y) % 5);
            src_mem[fwd] = orig_mem[i];
        end
        run_job(28, 1'b0, -1, -1, -1, -1);
        for (int i = 0; i < 25; i++) begin
            tests_run++;
            if (dst_mem[i] !== orig_mem[i]) begin
                tests_failed++;
                $display("FAIL round_trip[%0d]: got %h expected %h", i, dst_mem[i], orig_mem[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 25; i++) src_mem[i] = 64'(i);
        run_job(31, 1'b0, 5, 20, -1, -1);
        tests_run++;
        if (wr_count !== 25 || done_count !== 1 || done_cyc !== 27) begin
            tests_failed++;
            $display("FAIL start_ignored: writes %0d dones %0d done_cyc %0d expected 25/1/27",
                     wr_count, done_count, done_cyc);
        end
        tests_run++;
        if (rd_log[29] !== 1'b0 || ready_log[30] !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_restart: rd@29=%b ready@30=%b expected 0/1", rd_log[29], ready_log[30]);
        end
    endtask

    task automatic test_mid_reset();
        int busy;
        run_job(18, 1'b0, -1, -1, 12, 14);
        tests_run++;
        if (rd_log[11] !== 1'b1 || wr_log[11] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_active: rd/wr@11 got %b%b expected 11", rd_log[11], wr_log[11]);
        end
        tests_run++;
        if (rd_log[12] !== 1'b0 || wr_log[12] !== 1'b0 || ready_log[12] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_drop: rd/wr/ready@12 got %b%b%b expected 001",
                     rd_log[12], wr_log[12], ready_log[12]);
        end
        busy = 0;
        for (int c = 12; c <= 18; c++) if (rd_log[c] || wr_log[c]) busy++;
        tests_run++;
        if (busy !== 0 || done_count !== 0) begin
            tests_failed++;
            $display("FAIL reset_quiet: busy cycles %0d dones %0d expected 0/0", busy, done_count);
        end
        for (int i = 0; i < 25; i++) src_mem[i] = 64'(i) + 64'h100;
        run_job(28, 1'b0, -1, -1, -1, -1);
        tests_run++;
        if (wr_count !== 25 || $countones(seen) !== 25 || done_cyc !== 27) begin
            tests_failed++;
            $display("FAIL post_reset_run: writes %0d distinct %0d done_cyc %0d expected 25/25/27",
                     wr_count, $countones(seen), done_cyc);
        end
        tests_run++;
        if (dst_mem[6] !== 64'h101 || dst_mem[21] !== 64'h118) begin
            tests_failed++;
            $display("FAIL post_reset_data: dst[6]=%h dst[21]=%h expected 101/118", dst_mem[6], dst_mem[21]);
        end
    endtask

    task automatic test_back_to_back();
        run_job(29, 1'b1, -1, -1, -1, -1);
        tests_run++;
        if (ready_log[28] !== 1'b1 || rd_log[29] !== 1'b1 || rd_log[28] !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back: ready@28=%b rd@28=%b rd@29=%b expected 1/0/1",
                     ready_log[28], rd_log[28], rd_log[29]);
        end
        tests_run++;
        if (done_count !== 1 || wr_count !== 25) begin
            tests_failed++;
            $display("FAIL back_to_back_count: dones %0d writes %0d expected 1/25", done_count, wr_count);
        end
        idle_cycles(30);
    endtask

`ifdef INV_PERMUTE_ABORT_EN
    task automatic test_abort();
        abort_cyc = 10;
        run_job(16, 1'b0, -1, -1, -1, -1);
        abort_cyc = -1;
        tests_run++;
        if (ready_log[11] !== 1'b1 || rd_log[11] !== 1'b0 || wr_log[11] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle: ready/rd/wr@11 got %b%b%b expected 100",
                     ready_log[11], rd_log[11], wr_log[11]);
        end
        tests_run++;
        if (done_count !== 0 || wr_count > 9) begin
            tests_failed++;
            $display("FAIL abort_effect: dones %0d writes %0d expected 0 and <=9", done_count, wr_count);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.start    = 1'b0;
`ifdef INV_PERMUTE_ABORT_EN
        bus.abort    = 1'b0;
        abort_cyc    = -1;
`endif
        for (int i = 0; i < 25; i++) src_mem[i] = '0;
        test_reset();
        test_single_run();
        test_round_trip();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
`ifdef INV_PERMUTE_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inv_permute.md
INV_PERMUTE -- requirements
Module: inv_permute

Interface
REQ-001 Parameter: W, default 64, lane width in bits.
REQ-002 Parameter: LANES, fixed 25, number of lanes in a 5x5 state.
REQ-003 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  request to run one inverse permutation; sampled only in IDLE.
REQ-006 Port: ready  output  1  high while in IDLE.
REQ-007 Port: rd  output  1  source-memory read strobe.
REQ-008 Port: rd_addr  output  5  source lane index i = x+5y, range 0..24.
REQ-009 Port: rd_data  input  W  source lane, valid exactly one cycle after rd.
REQ-010 Port: wr  output  1  destination-memory write strobe.
REQ-011 Port: wr_addr  output  5  destination lane index, range 0..24.
REQ-012 Port: wr_data  output  W  destination lane value.
REQ-013 Port: done  output  1  one-cycle pulse when all 25 lanes are written.

Function
REQ-014 Mapping: source lane (X,Y) is written to destination (x,y) = ((X+3Y) mod 5, X); this undoes the forward permute (x,y)->(y,(2x+3y) mod 5).
REQ-015 States: IDLE, READ, DRAIN, DONE; 2-bit encoding IDLE=0, READ=1, DRAIN=2, DONE=3.
REQ-016 Transitions: IDLE->READ when start=1, else stay; READ->READ while cnt<24; READ->DRAIN when cnt=24; DRAIN->DONE; DONE->IDLE.
REQ-017 Lane counter cnt (5 bits) clears on IDLE->READ and increments by 1 each READ cycle; it never exceeds 24.
REQ-018 In READ: rd=1, rd_addr=cnt; rd=0 in all other states.
REQ-019 Write path: wr=1 in the cycle after every READ cycle (READ cycles 2..25 and DRAIN); wr_addr=map(cnt registered from the previous cycle), wr_data=rd_data passed through combinationally.
REQ-020 Latency: start accepted at edge 0; reads at cycles 1..25; writes at cycles 2..26; done=1 at cycle 27; ready=1 again at cycle 28.
REQ-021 Each destination index 0..24 is written exactly once per run; outputs driven from the state register only (Moore).
REQ-022 start is ignored in READ, DRAIN and DONE; back-to-back start held high restarts at cycle 28.
REQ-023 wr_addr and wr_data are 0 whenever wr=0; rd_addr is 0 whenever rd=0.

Reset
REQ-024 While rst=0: state=IDLE, cnt=0, write-valid register=0; hence ready=1, rd=0, wr=0, done=0, addresses and wr_data=0.
REQ-025 Reset asserted mid-run aborts immediately with no further rd/wr; a partial destination image is acceptable.
REQ-026 First start is accepted on the first rising edge after rst returns to 1.

Configuration
REQ-027 Macro INV_PERMUTE_ABORT_EN: when defined, adds input port abort (1 bit, after start); abort=1 in READ or DRAIN forces the next state to IDLE, clears cnt, suppresses the pending write, and produces no done pulse.
REQ-028 When INV_PERMUTE_ABORT_EN is not defined, the abort port does not exist and every run completes per REQ-020.

Structure
REQ-029 Package inv_permute_pkg holds: state typedef and encodings, LANES=25, IDX_W=5, and the last-lane constant 24.
REQ-030 Sub-module inv_permute_map: purely combinational 5-bit source index to 5-bit destination index, instantiated once in the write path.
REQ-031 Top module holds the FSM, cnt, and the one-cycle write-valid/index pipeline register.

Verification
REQ-032 Reset: hold rst=0 for 3 cycles with start=1 -> ready=1, rd=0, wr=0, done=0 throughout.
REQ-033 Single run, rd_data=lane index: writes observed (src->dst) 0->0, 1->6, 5->3, 24->21; 25 distinct wr_addr values; done exactly at cycle 27.
REQ-034 Round trip: random 25x64 image through the forward permute then inv_permute -> destination equals original image.
REQ-035 start pulsed at cycles 5 and 20 during a run -> ignored; exactly 25 writes and one done.
REQ-036 rst=0 at cycle 12 -> rd and wr drop in the same cycle; after release, start gives a full clean run.
REQ-037 With INV_PERMUTE_ABORT_EN, abort=1 at cycle 10 -> next cycle IDLE, ready=1, no done, at most 9 writes issued.
